// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_DATA,
    S_FINISH,
    S_DONE,
    S_ERROR
  } state_e;

  // True when an image of 'len' words cannot fit in 2**aw words of memory.
  function automatic logic len_too_big(input logic [15:0] len, input int unsigned aw);
    if (aw >= 16) return 1'b0;
    return 32'(len) > (32'd1 << aw);
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle watchdog: reloads on clear or when disabled, expires after
// TIMEOUT_CYCLES-1 consecutive enabled cycles without a clear.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= LOAD;
    end else if (i_clr || !i_en) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Fires on the cycle whose edge would complete the idle budget; a byte on
  // that same edge (i_clr) wins.
  assign o_expire = i_en && !i_clr && (r_cnt <= CW'(1));

endmodule

// File: rtl/imem_loader.sv
// Packs a length-prefixed big-endian byte stream into 32-bit words, writes them
// to instruction memory from address 0, and gates the core's run enable.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   running_switch,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   loading,
  output logic                   load_done,
  output logic                   load_error,
  output logic                   cpu_run
);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [7:0]               r_len_hi;
  logic [15:0]              r_last_idx;
  logic [15:0]              r_word_idx;
  logic [1:0]               r_byte_idx;
  logic [23:0]              r_asm;
  logic                     r_we;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [INSTR_WIDTH-1:0]   r_wdata;
  logic                     r_cpu_run;

  logic                     w_rx_ready;
  logic                     w_fire;
  logic                     w_tmo_en;
  logic                     w_expire;
  logic [15:0]              w_len;
  logic                     w_last_byte;
  logic                     w_last_word;

  assign w_len       = {r_len_hi, rx_data};
  assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign w_last_word = (r_word_idx == r_last_idx);
  assign w_fire      = rx_valid && w_rx_ready;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (w_tmo_en),
    .i_clr   (w_fire),
    .o_expire(w_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rx_ready  = 1'b0;
    w_tmo_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rx_ready = 1'b1;
        if (rx_valid) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_rx_ready = 1'b1;
        w_tmo_en   = 1'b1;
        if (rx_valid) begin
          if (w_len == '0)                         w_state_nxt = S_DONE;
          else if (len_too_big(w_len, ADDR_WIDTH)) w_state_nxt = S_ERROR;
          else                                     w_state_nxt = S_DATA;
        end else if (w_expire) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_DATA: begin
        w_rx_ready = 1'b1;
        w_tmo_en   = 1'b1;
        if (rx_valid) begin
          if (w_last_byte && w_last_word) w_state_nxt = S_FINISH;
        end else if (w_expire) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_FINISH: w_state_nxt = S_DONE;
      S_DONE: begin
        w_rx_ready = !running_switch;
        if (rx_valid && !running_switch) w_state_nxt = S_LEN_LO;
      end
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_len_hi   <= '0;
      r_last_idx <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_run  <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_cpu_run <= (r_state == S_DONE) && running_switch;
      if (w_fire) begin
        case (r_state)
          S_IDLE, S_DONE: r_len_hi <= rx_data;
          S_LEN_LO: begin
            r_last_idx <= w_len - 16'd1;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
          S_DATA: begin
            r_asm      <= {r_asm[15:0], rx_data};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) begin
              r_we       <= 1'b1;
              r_addr     <= ADDR_WIDTH'(r_word_idx);
              r_wdata    <= {r_asm, rx_data};
              r_word_idx <= r_word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The state qualifier keeps cpu_run low on the cycle a reload leaves DONE.
  assign cpu_run    = r_cpu_run && (r_state == S_DONE);
  assign rx_ready   = w_rx_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign loading    = (r_state == S_LEN_LO) || (r_state == S_DATA) || (r_state == S_FINISH);
  assign load_done  = (r_state == S_DONE);
  assign load_error = (r_state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against an image-level model.
module tb_imem_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 50;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          running_switch = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          loading;
  logic          load_done;
  logic          load_error;
  logic          cpu_run;

  always #5 clock = ~clock;

  imem_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .running_switch(running_switch),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .loading       (loading),
    .load_done     (load_done),
    .load_error    (load_error),
    .cpu_run       (cpu_run)
  );

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  int unsigned       cyc   = 0;
  int unsigned       t_we  = 0;
  int unsigned       t_hs  = 0;
  int unsigned       n_wr  = 0;
  logic [AW+31:0]    exp_q[$];
  logic [AW+31:0]    mon_e;
  logic [31:0]       img [0:1023];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every write must match the next word of the image in flight; the core
  // must never be enabled unless an image is resident.
  always @(negedge clock) begin
    if (reset_n) begin
      if (imem_we) begin
        n_wr++;
        t_we = cyc;
        if (exp_q.size() == 0) begin
          check("wr_unexpected_addr", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(mon_e[AW+31:32]));
          check("wr_data", imem_wdata, mon_e[31:0]);
        end
      end
      if (!load_done) check("run_gate", 32'(cpu_run), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned w = 0;
    repeat (gap) @(negedge clock);
    while (!rx_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", 32'(rx_ready), 32'd1);
      return;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    t_hs     = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic load_image(input int unsigned n, input int unsigned max_gap, input bit noise);
    logic [7:0]  lb[$];
    int unsigned g;
    lb.push_back(8'(n >> 8));
    lb.push_back(8'(n));
    for (int unsigned i = 0; i < n; i++) begin
      exp_q.push_back({AW'(i), img[i]});
      for (int k = 3; k >= 0; k--) lb.push_back(8'(img[i] >> (8 * k)));
    end
    running_switch = 1'b0;
    @(negedge clock);
    foreach (lb[j]) begin
      if (noise && j > 0) running_switch = 1'($urandom_range(0, 1));
      g = (j == 0 || max_gap == 0) ? 0 : $urandom_range(0, max_gap);
      send_byte(lb[j], g);
    end
    running_switch = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned n);
    int unsigned w = 0;
    while (!load_done && w < 50) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_done"}, 32'(load_done), 32'd1);
    if (n > 0) check({tag, "_lat"}, cyc - t_we, 32'd1);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_loading"}, 32'(loading), 32'd0);
    check({tag, "_rdy"}, 32'(rx_ready), 32'(!running_switch));
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rx_valid       = 1'b0;
    running_switch = 1'b0;
    reset_n        = 1'b0;
    #1;
    check({tag, "_we"},    32'(imem_we),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_wdata"}, imem_wdata,      32'd0);
    check({tag, "_flags"}, {29'd0, loading, load_done, load_error}, 32'd0);
    check({tag, "_run"},   32'(cpu_run),    32'd0);
    check({tag, "_rdy"},   32'(rx_ready),   32'd1);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_toggle(input string tag);
    running_switch = 1'b1;
    #1;
    check({tag, "_run_lat"}, 32'(cpu_run), 32'd0);
    @(negedge clock);
    check({tag, "_run_on"}, 32'(cpu_run), 32'd1);
    check({tag, "_rdy_run"}, 32'(rx_ready), 32'd0);
    running_switch = 1'b0;
    @(negedge clock);
    check({tag, "_run_off"}, 32'(cpu_run), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned w;
    int unsigned c0;
    int unsigned n_wr0;

    do_reset("rst0");

    // Two-instruction program, back-to-back bytes.
    img[0] = 32'h2008_0090;
    img[1] = 32'hAC08_0000;
    load_image(2, 0, 1'b0);
    wait_done("prog", 2);
    run_toggle("prog");

    // Reload a single zero word over address 0.
    exp_q.push_back({AW'(0), 32'h0});
    send_byte(8'h00, 0);
    check("reload_drop", 32'(load_done), 32'd0);
    check("reload_loading", 32'(loading), 32'd1);
    send_byte(8'h01, 0);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
    wait_done("reload", 1);

    // Empty image.
    n_wr0 = n_wr;
    load_image(0, 0, 1'b0);
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_nwr", n_wr - n_wr0, 32'd0);
    run_toggle("empty");

    // Random images with random gaps and a noisy run switch.
    repeat (6) begin
      n = $urandom_range(2, 12);
      for (int unsigned i = 0; i < n; i++) img[i] = $urandom;
      load_image(n, 3, 1'b1);
      wait_done("rnd", n);
      run_toggle("rnd");
    end

    // Reset partway through a word, then a fresh one-word image.
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset("rst_mid");
    img[0] = $urandom;
    load_image(1, 0, 1'b0);
    wait_done("fresh", 1);

    // A byte arriving exactly as the idle budget runs out is accepted.
    exp_q.push_back({AW'(0), 32'hCAFE_F00D});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hCA, TMO - 2);
    send_byte(8'hFE, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h0D, 0);
    wait_done("tmo_edge", 1);

    // Largest image that fits.
    for (int unsigned i = 0; i < 1024; i++) img[i] = $urandom;
    load_image(1024, 0, 1'b0);
    wait_done("full", 1024);

    // One word too many.
    n_wr0 = n_wr;
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("big_err", 32'(load_error), 32'd1);
    check("big_rdy", 32'(rx_ready), 32'd0);
    check("big_flags", {30'd0, loading, load_done}, 32'd0);
    running_switch = 1'b1;
    rx_data        = 8'hFF;
    rx_valid       = 1'b1;
    repeat (3) @(negedge clock);
    check("big_run", 32'(cpu_run), 32'd0);
    check("big_hold", 32'(load_error), 32'd1);
    check("big_nwr", n_wr - n_wr0, 32'd0);
    rx_valid = 1'b0;
    do_reset("rst_big");

    // Stall mid-word until the watchdog aborts the transfer.
    n_wr0 = n_wr;
    load_image(0, 0, 1'b0);
    do_reset("rst_tmo");
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    c0 = t_hs;
    w  = 0;
    while (!load_error && w < 60) begin
      @(negedge clock);
      w++;
    end
    check("tmo_at", cyc - c0, TMO - 1);
    repeat (11) @(negedge clock);
    check("tmo_hold", 32'(load_error), 32'd1);
    check("tmo_done", 32'(load_done), 32'd0);
    check("tmo_nwr", n_wr - n_wr0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
